// File: rtl/bitbakery_serial_pkg.sv
// Shared types and sizing helpers for the BitBakery serial frame transmitter.
// The optional 8E1 frame is selected with the BITBAKERY_TX_PARITY_EN macro.
package bitbakery_serial_pkg;

   typedef enum logic [2:0] {
      GAP    = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   localparam int NUM_BYTES = 4;
   localparam int DATA_BITS = 8;

   // A counter needs at least one bit, even when the count range is degenerate.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int clk_cnt_w(input int clks_per_bit);
      return cnt_w(clks_per_bit);
   endfunction

   function automatic int gap_cnt_w(input int gap_bits);
      return cnt_w(gap_bits + 1);
   endfunction

endpackage

// File: rtl/bitbakery_serial_frame_tx_baud.sv
// Bit-time divider: one-cycle tick on the last clock of every bit period.
// A synchronous clear restarts the bit period from zero.
module serial_baud_tick
   import bitbakery_serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int CW = clk_cnt_w(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (clr || tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/bitbakery_serial_frame_tx.sv
// Free-running UART transmitter: 4-byte packet then GAP_BITS idle bit-times, forever.
// Define BITBAKERY_TX_PARITY_EN for 8E1 frames instead of 8N1.
module bitbakery_serial_frame_tx
   import bitbakery_serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int GAP_BITS     = 10
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] D0,
   input  logic [7:0] D1,
   input  logic [7:0] D2,
   input  logic [7:0] D3,
   output logic       saida_serial
);

   localparam int GW = gap_cnt_w(GAP_BITS);
   localparam int BW = $clog2(DATA_BITS);
   localparam int IW = $clog2(NUM_BYTES);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_BITS - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
   localparam logic [IW-1:0] BYTE_LAST = IW'(NUM_BYTES - 1);

   tx_state_e state, state_nxt;
   logic [GW-1:0] gap_cnt, gap_nxt;
   logic [BW-1:0] bit_cnt, bit_nxt;
   logic [IW-1:0] byte_idx, byte_nxt;
   logic [NUM_BYTES-1:0][DATA_BITS-1:0] snap;
   logic load_snap;
   logic line_nxt;
   logic tick;

   // Bit periods run back-to-back without interruption, so the divider is never cleared.
   serial_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clock (clock),
      .reset (reset),
      .clr   (1'b0),
      .tick  (tick)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= GAP;
         gap_cnt  <= '0;
         bit_cnt  <= '0;
         byte_idx <= '0;
      end else begin
         state    <= state_nxt;
         gap_cnt  <= gap_nxt;
         bit_cnt  <= bit_nxt;
         byte_idx <= byte_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      gap_nxt   = gap_cnt;
      bit_nxt   = bit_cnt;
      byte_nxt  = byte_idx;
      load_snap = 1'b0;
      case (state)
         GAP: if (tick) begin
            if (gap_cnt == GAP_LAST) begin
               state_nxt = START;
               gap_nxt   = '0;
               load_snap = 1'b1;
            end else begin
               gap_nxt = gap_cnt + 1'b1;
            end
         end
         START: if (tick) begin
            state_nxt = DATA;
            bit_nxt   = '0;
         end
         DATA: if (tick) begin
            if (bit_cnt == BIT_LAST) begin
`ifdef BITBAKERY_TX_PARITY_EN
               state_nxt = PARITY;
`else
               state_nxt = STOP;
`endif
               bit_nxt = '0;
            end else begin
               bit_nxt = bit_cnt + 1'b1;
            end
         end
`ifdef BITBAKERY_TX_PARITY_EN
         PARITY: if (tick) state_nxt = STOP;
`endif
         STOP: if (tick) begin
            if (byte_idx == BYTE_LAST) begin
               state_nxt = GAP;
               byte_nxt  = '0;
            end else begin
               state_nxt = START;
               byte_nxt  = byte_idx + 1'b1;
            end
         end
         default: state_nxt = GAP;
      endcase
   end

   // Whole packet captured at once so a packet never mixes old and new bytes.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         snap <= '0;
      else if (load_snap)
         snap <= {D3, D2, D1, D0};
   end

   always_comb begin
      line_nxt = 1'b1;
      case (state)
         START:   line_nxt = 1'b0;
         DATA:    line_nxt = snap[byte_idx][bit_cnt];
`ifdef BITBAKERY_TX_PARITY_EN
         PARITY:  line_nxt = ^snap[byte_idx];
`endif
         default: line_nxt = 1'b1;
      endcase
   end

   // The line trails the state by one clock, which lands the first start edge
   // exactly GAP_BITS*CLKS_PER_BIT clocks after reset release.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         saida_serial <= 1'b1;
      else
         saida_serial <= line_nxt;
   end

endmodule

// File: tb/tb_bitbakery_serial_frame_tx.sv
// Self-checking bench: bit-time waveform model for a small-divider instance,
// run-length checks for a default-parameter instance.
module tb_bitbakery_serial_frame_tx;

   localparam int C  = 4;
   localparam int G  = 2;
`ifdef BITBAKERY_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   localparam int P  = (4 * FB + G) * C;
   localparam int CD = 434;
   localparam int GD = 10;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic rst_a, rst_b;
   logic [7:0] d0, d1, d2, d3, e0, e1, e2, e3;
   logic line_a, line_b;
   logic [3:0][7:0] pk;
   int n;
   int n_checks = 0;
   int n_fail   = 0;

   bitbakery_serial_frame_tx #(.CLKS_PER_BIT(C), .GAP_BITS(G)) dut (
      .clock(clock), .reset(rst_a), .D0(d0), .D1(d1), .D2(d2), .D3(d3),
      .saida_serial(line_a)
   );

   bitbakery_serial_frame_tx dut_def (
      .clock(clock), .reset(rst_b), .D0(e0), .D1(e1), .D2(e2), .D3(e3),
      .saida_serial(line_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected line level after clock edge k of a packet (edge 0 = first edge of the gap).
   function automatic logic model_bit(input logic [3:0][7:0] b, input int k);
      logic q[$];
      for (int g = 0; g < G; g++) q.push_back(1'b1);
      for (int i = 0; i < 4; i++) begin
         q.push_back(1'b0);
         for (int j = 0; j < 8; j++) q.push_back(b[i][j]);
`ifdef BITBAKERY_TX_PARITY_EN
         q.push_back(^b[i]);
`endif
         q.push_back(1'b1);
      end
      return q[k / C];
   endfunction

   task automatic check_packet(input string tag, input logic [3:0][7:0] b, input int ncyc);
      for (int k = 0; k < ncyc; k++) begin
         @(posedge clock);
         #1;
         chk($sformatf("%s k=%0d", tag, k), 32'(line_a), 32'(model_bit(b, k)));
      end
   endtask

   task automatic run_len(input logic lvl, input int init, output int len);
      len = init;
      do begin
         @(posedge clock);
         #1;
         if (line_b === lvl) len++;
      end while (line_b === lvl && len < 20000);
   endtask

   initial begin
      rst_a = 1'b0; rst_b = 1'b0;
      d0 = 8'h35; d1 = 8'h4A; d2 = 8'h90; d3 = 8'hC0;
      e0 = 8'h00; e1 = 8'hFF; e2 = 8'h55; e3 = 8'hAA;
      repeat (3) @(posedge clock);
      #1;
      chk("reset_line_a", 32'(line_a), 32'd1);
      chk("reset_line_b", 32'(line_b), 32'd1);

      // Default parameters: gap, then start + zero data (+ zero parity), stop, next start.
      rst_b = 1'b1;
      run_len(1'b1, 0, n); chk("def_gap_high", n, GD * CD);
      run_len(1'b0, 1, n); chk("def_d0_low", n, (FB - 1) * CD);
      run_len(1'b1, 1, n); chk("def_d0_stop", n, CD);
      run_len(1'b0, 1, n); chk("def_d1_start", n, CD);
      rst_b = 1'b0;

      // Small divider: directed packets, snapshot coherence, randomized packets.
      rst_a = 1'b1;
      pk = {d3, d2, d1, d0};
      check_packet("pkt0", pk, P);
      fork
         check_packet("pkt1_snapshot", pk, P);
         begin
            repeat (G * C + 3 * C) @(posedge clock);
            #2 d1 = 8'h7F;
         end
      join
      pk = {d3, d2, d1, d0};
      check_packet("pkt2_new_d1", pk, P);

`ifdef BITBAKERY_TX_PARITY_EN
      d0 = 8'h07; pk = {d3, d2, d1, d0};
      check_packet("par_07", pk, P);
      d0 = 8'h03; pk = {d3, d2, d1, d0};
      check_packet("par_03", pk, P);
`endif

      for (int r = 0; r < 3; r++) begin
         {d3, d2, d1, d0} = $urandom;
         pk = {d3, d2, d1, d0};
         check_packet($sformatf("rand%0d", r), pk, P);
      end

      // Abort mid-D2 data bits, then the sequence restarts from the gap with D0 first.
      {d3, d2, d1, d0} = 32'hC0_90_7F_35;
      pk = {d3, d2, d1, d0};
      check_packet("pre_reset", pk, G * C + 2 * FB * C + 4 * C);
      #3 rst_a = 1'b0;
      #1 chk("async_reset_high", 32'(line_a), 32'd1);
      repeat (2) begin
         @(posedge clock);
         #1;
         chk("reset_hold_high", 32'(line_a), 32'd1);
      end
      rst_a = 1'b1;
      {d3, d2, d1, d0} = $urandom;
      pk = {d3, d2, d1, d0};
      check_packet("post_reset", pk, P);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
